// File: rtl/sramc_pkg.sv
// -----------------------------------------------------------------------------
// sramc_pkg
// Shared definitions for the SRAM controller AHB-Lite slave:
//   - AHB htrans / hresp / hsize encodings
//   - slave FSM state enumeration
// No ports (package).
// -----------------------------------------------------------------------------
package sramc_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;

    // ST_RREG is only reachable when SRAMC_RDATA_REG_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RREG,
        ST_RDATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/sramc_ahb_slave_if.sv
// -----------------------------------------------------------------------------
// sramc_ahb_slave_if
// AHB-Lite signal bundle between a bus master/decoder and the SRAM controller
// slave stage.
//   master modport: drives hsel, haddr, hwrite, htrans, hsize, hburst, hwdata,
//                   hready; receives hrdata, hready_resp, hresp
//   slave modport : the reverse
// -----------------------------------------------------------------------------
interface sramc_ahb_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic                  hwrite;
    logic [1:0]            htrans;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hready_resp;
    logic [1:0]            hresp;

    modport master (
        output hsel, haddr, hwrite, htrans, hsize, hburst, hwdata, hready,
        input  hrdata, hready_resp, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, htrans, hsize, hburst, hwdata, hready,
        output hrdata, hready_resp, hresp
    );
endinterface

// File: rtl/sramc_lane_dec.sv
// -----------------------------------------------------------------------------
// sramc_lane_dec
// Combinational byte-lane decoder.
//   hsize_i     : AHB transfer size
//   addr_lo_i   : haddr[1:0]
//   lane_mask_o : one bit per byte lane, 1 = lane takes part in the transfer
//   illegal_o   : size above word, or misaligned half/word access
// -----------------------------------------------------------------------------
module sramc_lane_dec
    import sramc_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic [2:0]           hsize_i,
    input  logic [1:0]           addr_lo_i,
    output logic [NUM_LANES-1:0] lane_mask_o,
    output logic                 illegal_o
);

    always_comb begin
        lane_mask_o = '0;
        illegal_o   = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: lane_mask_o = NUM_LANES'(1) << addr_lo_i;
            HSIZE_HALF: begin
                lane_mask_o = NUM_LANES'(3) << {addr_lo_i[1], 1'b0};
                illegal_o   = addr_lo_i[0];
            end
            HSIZE_WORD: begin
                lane_mask_o = '1;
                illegal_o   = |addr_lo_i;
            end
            default:    illegal_o = 1'b1;
        endcase
        // An illegal transfer must never touch the SRAM.
        if (illegal_o) begin
            lane_mask_o = '0;
        end
    end

endmodule

// File: rtl/sramc_ahb_slave.sv
// -----------------------------------------------------------------------------
// sramc_ahb_slave
// AHB-Lite slave stage of the SRAM controller. Registers the address phase and
// drives two SRAM banks (NUM_LANES byte-lane macros each) in the data phase.
// Writes complete with zero wait states, reads with one (two when
// SRAMC_RDATA_REG_EN is defined, which registers SRAM read data in an extra
// RREG state). Illegal transfers get a two-cycle ERROR response.
//
// Ports:
//   hclk, hresetn        clock, asynchronous active-low reset
//   ahb (slave modport)  AHB-Lite bus signals and responses
//   sram_addr            word address within a bank (haddr[14:2])
//   sram_wdata           write data shared by both banks
//   sram_wen             active-low write enable
//   sram_csn0/1          active-low per-lane chip selects, bank 0 / bank 1
//   sram_q0/1            bank read data, valid one cycle after a read select
//
// Optional macro: SRAMC_RDATA_REG_EN
// -----------------------------------------------------------------------------
module sramc_ahb_slave
    import sramc_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 13,
    parameter int SRAM_DATA_WIDTH = 8,
    parameter int NUM_LANES       = DATA_WIDTH / SRAM_DATA_WIDTH
) (
    input  logic                       hclk,
    input  logic                       hresetn,
    sramc_ahb_slave_if.slave           ahb,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]      sram_wdata,
    output logic                       sram_wen,
    output logic [NUM_LANES-1:0]       sram_csn0,
    output logic [NUM_LANES-1:0]       sram_csn1,
    input  logic [DATA_WIDTH-1:0]      sram_q0,
    input  logic [DATA_WIDTH-1:0]      sram_q1
);

    localparam int BANK_BIT = SRAM_ADDR_WIDTH + 2;

    state_e                     state_q, state_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q;
    logic                       bank_q;
    logic [NUM_LANES-1:0]       lanes_q;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;

    logic [NUM_LANES-1:0]       lane_mask;
    logic                       illegal;
    logic                       accept;
    logic                       sample;
    logic [DATA_WIDTH-1:0]      q_sel;
    state_e                     next_xfer;

    // hburst and the upper address bits carry no information for this slave.
    logic unused_bits;
    assign unused_bits = ^{ahb.hburst, ahb.htrans[0], ahb.haddr[ADDR_WIDTH-1:BANK_BIT+1]};

    sramc_lane_dec #(
        .NUM_LANES (NUM_LANES)
    ) u_lane_dec (
        .hsize_i     (ahb.hsize),
        .addr_lo_i   (ahb.haddr[1:0]),
        .lane_mask_o (lane_mask),
        .illegal_o   (illegal)
    );

    assign accept = ahb.hsel & ahb.hready & ahb.htrans[1];

    // Only states that drive hready_resp high can see a new address phase.
    assign sample = accept && (state_q == ST_IDLE || state_q == ST_WR ||
                               state_q == ST_RDATA || state_q == ST_ERR2);

    assign q_sel     = bank_q ? sram_q1 : sram_q0;
    assign sram_addr = addr_q;

    always_comb begin
        next_xfer = ST_IDLE;
        if (sample) begin
            if (illegal)          next_xfer = ST_ERR1;
            else if (ahb.hwrite)  next_xfer = ST_WR;
            else                  next_xfer = ST_RD;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            bank_q  <= 1'b0;
            lanes_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (sample) begin
                addr_q  <= ahb.haddr[BANK_BIT-1:2];
                bank_q  <= ahb.haddr[BANK_BIT];
                lanes_q <= lane_mask;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rdata_d         = rdata_q;
        ahb.hrdata      = rdata_q;
        ahb.hready_resp = 1'b1;
        ahb.hresp       = HRESP_OKAY;
        sram_csn0       = '1;
        sram_csn1       = '1;
        sram_wen        = 1'b1;
        sram_wdata      = '0;

        unique case (state_q)
            ST_IDLE: state_d = next_xfer;

            ST_WR: begin
                sram_csn0  = bank_q ? '1 : ~lanes_q;
                sram_csn1  = bank_q ? ~lanes_q : '1;
                sram_wen   = 1'b0;
                sram_wdata = ahb.hwdata;
                state_d    = next_xfer;
            end

            ST_RD: begin
                sram_csn0       = bank_q ? '1 : ~lanes_q;
                sram_csn1       = bank_q ? ~lanes_q : '1;
                ahb.hready_resp = 1'b0;
`ifdef SRAMC_RDATA_REG_EN
                state_d         = ST_RREG;
`else
                state_d         = ST_RDATA;
`endif
            end

`ifdef SRAMC_RDATA_REG_EN
            ST_RREG: begin
                // Capture SRAM output here; RDATA then drives hrdata from rdata_q.
                ahb.hready_resp = 1'b0;
                rdata_d         = q_sel;
                state_d         = ST_RDATA;
            end

            ST_RDATA: state_d = next_xfer;
`else
            ST_RDATA: begin
                // Pass SRAM output straight through and keep a copy so hrdata
                // holds once the read is over.
                ahb.hrdata = q_sel;
                rdata_d    = q_sel;
                state_d    = next_xfer;
            end
`endif

            ST_ERR1: begin
                ahb.hresp       = HRESP_ERROR;
                ahb.hready_resp = 1'b0;
                state_d         = ST_ERR2;
            end

            ST_ERR2: begin
                ahb.hresp = HRESP_ERROR;
                state_d   = next_xfer;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/sramc_ahb_slave.md
Name: sramc_ahb_slave

Overview:
- AHB-Lite slave stage of the SRAM controller; consumes the AHB signal bundle and converts each accepted transfer into SRAM bank control.
- SRAM side: two banks, each 4 byte lanes of 8K x 8.
- Registers the address phase, drives SRAM chip selects, write enable, address and write data in the data phase, and returns hrdata/hready_resp/hresp.
- Adds one wait state on reads; detects illegal transfers and returns a two-cycle ERROR response.

Parameters:
- ADDR_WIDTH, 32, AHB address width
- DATA_WIDTH, 32, AHB data width
- SRAM_ADDR_WIDTH, 13, word address width per bank
- SRAM_DATA_WIDTH, 8, width of one byte-lane macro
- NUM_LANES, 4, byte lanes per bank (DATA_WIDTH/SRAM_DATA_WIDTH)

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  ADDR_WIDTH  address
- hwrite  in  1  1 = write
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- hsize  in  3  transfer size
- hburst  in  3  burst type; accepted, not used
- hwdata  in  DATA_WIDTH  write data
- hready  in  1  bus ready (previous transfer complete)
- hrdata  out  DATA_WIDTH  read data
- hready_resp  out  1  slave ready
- hresp  out  2  00 OKAY, 01 ERROR
- sram_addr  out  SRAM_ADDR_WIDTH  word address = haddr[14:2]
- sram_wdata  out  DATA_WIDTH  write data to both banks
- sram_wen  out  1  active-low write enable
- sram_csn0  out  NUM_LANES  bank0 lane chip selects, active-low
- sram_csn1  out  NUM_LANES  bank1 lane chip selects, active-low
- sram_q0  in  DATA_WIDTH  bank0 read data, valid one cycle after csn low with wen high
- sram_q1  in  DATA_WIDTH  bank1 read data

Behaviour:
- Clock and reset: one clock hclk; reset hresetn asynchronous, active-low.
- Reset values: hready_resp=1, hresp=OKAY, hrdata=0, sram_csn0/1=all 1, sram_wen=1, sram_addr=0, sram_wdata=0; FSM=IDLE.
- Accept condition: hsel & hready & htrans[1] (NONSEQ or SEQ). On accept, register haddr, hwrite, hsize, bank=haddr[15].
- IDLE/BUSY or unselected transfers: OKAY, zero wait, no SRAM access.
- Illegal transfer: hsize>2, halfword with haddr[0]=1, or word with haddr[1:0]!=0.
- Lane enables:
  - byte: lane haddr[1:0]
  - half: lanes {haddr[1],0}, {haddr[1],1}
  - word: all four lanes
  - Only the selected bank's csn lanes go low.
- FSM:
  - IDLE -> WR on legal write accept.
  - IDLE -> RD on legal read accept.
  - IDLE -> ERR1 on illegal accept.
  - WR (data phase): csn low, wen=0, sram_wdata=hwdata, hready_resp=1. Zero wait. Next state per a new accept in the same cycle, else IDLE.
  - RD: csn low, wen=1, hready_resp=0. Always -> RDATA.
  - RDATA: hrdata = registered bank ? sram_q1 : sram_q0; hready_resp=1. Next state per a new accept, else IDLE.
  - ERR1: hresp=ERROR, hready_resp=0, no SRAM access -> ERR2.
  - ERR2: hresp=ERROR, hready_resp=1. Next state per a new accept.
- Latency: write 0 wait states; read 1 wait state (hrdata valid 2 cycles after the address phase).
- Address phases presented while hready_resp=0 are not sampled, because bus hready is low.
- Back-to-back write then read: the write completes in the read's address-phase cycle; the read issues the following cycle. No hazard and no stall beyond the read wait state.
- hsel low in the same cycle as a data phase: the current data phase still completes.
- Reset mid-transfer: the transfer is dropped and all outputs return to reset values immediately.
- hrdata holds its last value outside RDATA.

Optional Feature:
- Macro SRAMC_RDATA_REG_EN.
- Defined: an extra RREG state is inserted between RD and RDATA. The SRAM output is registered in RREG and hrdata is driven from that register. Reads take 2 wait states. Writes are unchanged.
- Undefined: 1-wait-state read path as above.

Decomposition:
- Package sramc_pkg holds:
  - htrans codes (IDLE/BUSY/NONSEQ/SEQ)
  - hresp codes (OKAY/ERROR)
  - hsize codes (BYTE/HALF/WORD)
  - FSM state enum
- Sub-module sramc_lane_dec: combinational hsize + haddr[1:0] -> lane mask (NUM_LANES) and illegal flag.

Test Plan:
- Word write haddr=0x0000_0010, hwdata=0xA5A5_1234 -> next cycle sram_csn0=0000, sram_csn1=1111, wen=0, sram_addr=4, hready_resp=1, hresp=OKAY.
- Byte write haddr=0x0000_8003 then word read 0x0000_8000 -> csn1=0111 for the write; the read gives hready_resp=0 for one cycle, then hrdata=sram_q1.
- Halfword access at haddr=0x0000_0001 -> two-cycle ERROR (hready_resp 0 then 1, hresp=01), csn stay 1111.
- Back-to-back NONSEQ write/read/write at 0x0/0x4/0x8 -> total 4 data-phase cycles, exactly one wait state.
- hresetn asserted during RD -> outputs immediately return to reset values; next read after release completes normally.
- With SRAMC_RDATA_REG_EN -> word read shows 2 wait cycles, hrdata correct on the third cycle.
